// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - key input and conditioned event bundle for key_conditioner
// Ports (signals):
//   key_raw      raw asynchronous button levels into the conditioner
//   key_level    debounced pressed state, 1 = pressed
//   key_press    one-cycle pulse on accepted press
//   key_release  one-cycle pulse on accepted release
//   key_repeat   one-cycle auto-repeat pulse while held
//   step         OR of all press and repeat bits
// Modports: master = key source / event consumer, slave = conditioner.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic                step;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  step
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output step
    );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer and press/release/repeat pulse generator
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    key_conditioner_if.slave: key_raw in; key_level, key_press,
//          key_release, key_repeat, step out
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    key_conditioner_if.slave bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

    // Raw level that means "not pressed"; synchroniser resets to it.
    localparam logic [NUM_KEYS-1:0] RAW_IDLE = {NUM_KEYS{1'(ACTIVE_LOW != 0)}};

    logic [NUM_KEYS-1:0] sync0;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] s_q;

    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] rel_vec;
    logic [NUM_KEYS-1:0] rep_vec;

    // Two synchroniser flops, then a registered polarity-correction stage
    // so the FSM always sees s = 1 for pressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= RAW_IDLE;
            sync1 <= RAW_IDLE;
            s_q   <= '0;
        end else begin
            sync0 <= bus.key_raw;
            sync1 <= sync0;
            s_q   <= (ACTIVE_LOW != 0) ? ~sync1 : sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [1:0]  state;
        logic [31:0] cnt;
        logic [31:0] rcnt;
        logic        first_done;
        logic        lvl_q;
        logic        prs_q;
        logic        rel_q;
        logic        rep_q;
        logic        s;

        assign s = s_q[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state      <= IDLE;
                cnt        <= '0;
                rcnt       <= '0;
                first_done <= 1'b0;
                lvl_q      <= 1'b0;
                prs_q      <= 1'b0;
                rel_q      <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                rep_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= DB_PRESS;
                            cnt   <= 32'd1;
                        end
                    end
                    DB_PRESS: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state      <= HELD;
                            lvl_q      <= 1'b1;
                            prs_q      <= 1'b1;
                            rcnt       <= '0;
                            first_done <= 1'b0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state <= DB_RELEASE;
                            cnt   <= 32'd1;
                        end else if (REPEAT_EN != 0) begin
                            // rcnt restarts after each repeat; the compare value
                            // switches from the initial delay to the period.
                            if (rcnt == (first_done ? RP_LAST : RD_LAST)) begin
                                rep_q      <= 1'b1;
                                rcnt       <= '0;
                                first_done <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 32'd1;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        // A bounce back to pressed resumes HELD; rcnt is left
                        // untouched so the repeat schedule only pauses.
                        if (s) begin
                            state <= HELD;
                        end else if (cnt == DB_LAST) begin
                            state <= IDLE;
                            lvl_q <= 1'b0;
                            rel_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign level_vec[i] = lvl_q;
        assign press_vec[i] = prs_q;
        assign rel_vec[i]   = rel_q;
        assign rep_vec[i]   = rep_q;
    end

    assign bus.key_level   = level_vec;
    assign bus.key_press   = press_vec;
    assign bus.key_release = rel_vec;
    assign bus.key_repeat  = rep_vec;
    // Combinational OR of registered pulses: coincident events on several
    // keys collapse into a single step.
    assign bus.step        = |(press_vec | rep_vec);
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;
    localparam int NK = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    key_conditioner_if #(.NUM_KEYS(NK)) bus ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling or changing inputs.
    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " level"},   32'(bus.key_level),   32'd0);
        check_val({tag, " press"},   32'(bus.key_press),   32'd0);
        check_val({tag, " release"}, 32'(bus.key_release), 32'd0);
        check_val({tag, " repeat"},  32'(bus.key_repeat),  32'd0);
        check_val({tag, " step"},    32'(bus.step),        32'd0);
    endtask

    task automatic idle_edges(input int n);
        for (int k = 0; k < n; k++) edge_step();
    endtask

    initial begin
        logic pat [9];
        int   n_press;
        int   n_rel;
        int   n_rep;
        int   press_at;

        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n       = 1'b0;
        bus.key_raw = 2'b11;
        idle_edges(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_edges(5);
        check_all_zero("idle");

        // Clean press on key 0: pulse at edge 6, level from edge 6
        bus.key_raw = 2'b10;
        for (int e = 0; e <= 8; e++) begin
            edge_step();
            check_val($sformatf("press e%0d", e), 32'(bus.key_press), (e == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("press step e%0d", e), 32'(bus.step), (e == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("press level e%0d", e), 32'(bus.key_level), (e >= 6) ? 32'd1 : 32'd0);
        end

        // Clean release: pulse at edge 6 after the raw change, no repeat
        bus.key_raw = 2'b11;
        for (int e = 0; e <= 8; e++) begin
            edge_step();
            check_val($sformatf("rel e%0d", e), 32'(bus.key_release), (e == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("rel level e%0d", e), 32'(bus.key_level), (e < 6) ? 32'd1 : 32'd0);
            check_val($sformatf("rel repeat e%0d", e), 32'(bus.key_repeat), 32'd0);
        end
        idle_edges(4);

        // Bounce: single press after the final run of 4 lows (edge 11)
        n_press  = 0;
        n_rel    = 0;
        press_at = -1;
        for (int e = 0; e <= 14; e++) begin
            bus.key_raw[0] = (e < 9) ? pat[e] : 1'b0;
            edge_step();
            if (bus.key_press[0]) begin
                n_press++;
                press_at = e;
            end
            if (bus.key_release[0]) n_rel++;
        end
        check_val("bounce press count", 32'(n_press), 32'd1);
        check_val("bounce press edge", 32'(press_at), 32'd11);
        check_val("bounce release count", 32'(n_rel), 32'd0);
        bus.key_raw = 2'b11;
        n_rel = 0;
        n_rep = 0;
        for (int e = 0; e <= 9; e++) begin
            edge_step();
            if (bus.key_release[0]) n_rel++;
            if (bus.key_repeat[0]) n_rep++;
        end
        check_val("bounce final release count", 32'(n_rel), 32'd1);
        check_val("bounce repeat count", 32'(n_rep), 32'd0);
        idle_edges(4);

        // Hold: press at 6, repeats at 16,21,26,31,36, release at 44
        bus.key_raw = 2'b10;
        n_rep = 0;
        for (int e = 0; e <= 48; e++) begin
            if (e == 38) bus.key_raw = 2'b11;
            edge_step();
            if (bus.key_repeat[0]) n_rep++;
            check_val($sformatf("hold repeat e%0d", e), 32'(bus.key_repeat),
                      (e == 16 || e == 21 || e == 26 || e == 31 || e == 36) ? 32'd1 : 32'd0);
            check_val($sformatf("hold step e%0d", e), 32'(bus.step),
                      (e == 6 || e == 16 || e == 21 || e == 26 || e == 31 || e == 36) ? 32'd1 : 32'd0);
            check_val($sformatf("hold release e%0d", e), 32'(bus.key_release), (e == 44) ? 32'd1 : 32'd0);
        end
        check_val("hold repeat count", 32'(n_rep), 32'd5);
        idle_edges(4);

        // Simultaneous press on both keys: one step cycle
        bus.key_raw = 2'b00;
        for (int e = 0; e <= 8; e++) begin
            edge_step();
            check_val($sformatf("dual press e%0d", e), 32'(bus.key_press), (e == 6) ? 32'd3 : 32'd0);
            check_val($sformatf("dual step e%0d", e), 32'(bus.step), (e == 6) ? 32'd1 : 32'd0);
        end
        check_val("dual level", 32'(bus.key_level), 32'd3);
        bus.key_raw = 2'b11;
        for (int e = 0; e <= 8; e++) begin
            edge_step();
            check_val($sformatf("dual rel e%0d", e), 32'(bus.key_release), (e == 6) ? 32'd3 : 32'd0);
        end
        idle_edges(4);

        // Reset mid-hold, key still held: fresh press 6 edges after release of reset
        bus.key_raw = 2'b10;
        idle_edges(9);
        check_val("pre-reset level", 32'(bus.key_level), 32'd1);
        rst_n = 1'b0;
        edge_step();
        check_all_zero("mid-hold reset");
        rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            edge_step();
            check_val($sformatf("post-reset press e%0d", e), 32'(bus.key_press), (e == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("post-reset level e%0d", e), 32'(bus.key_level), (e >= 6) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
